// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-side, D-side and memory-side signals of the
// cacheline memory arbiter.
//   master : the arbiter's view. It receives the requests and m_rdata/m_resp,
//            and drives the memory request, the responses and busy.
//   slave  : the environment's view (caches plus memory model), with every
//            direction reversed.
// I side : i_addr, i_read -> i_rdata, i_resp
// D side : d_addr, d_read, d_write, d_wdata -> d_rdata, d_resp
// Memory : m_addr, m_read, m_write, m_wdata -> m_rdata, m_resp
// Status : busy
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] m_addr;
  logic              m_read;
  logic              m_write;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  logic              busy;

  modport master (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata, busy
  );

  modport slave (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cacheline-wide memory port between the instruction
// fetch requester (I) and the data requester (D). D has fixed priority, but
// after STARVE_MAX consecutive D grants with I waiting, the next grant goes
// to I. Only one transaction is outstanding at a time. The request fields
// are latched at grant, so the memory side never sees requester inputs
// directly.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : mem_arbiter_if.master (I side, D side and memory signals, busy)
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  state_t            state_r;
  state_t            state_n_s;
  op_t               op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic [CNT_W-1:0]  starve_cnt_r;

  logic              d_req_s;
  logic              grant_d_s;
  logic              grant_i_s;

  // Arbitration decision; only meaningful in IDLE.
  always_comb begin
    d_req_s   = bus.d_read | bus.d_write;
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if (state_r == IDLE) begin
      // D wins unless I is waiting and D has already used up its quota.
      grant_d_s = d_req_s && (!bus.i_read || (starve_cnt_r < STARVE_MAX_C));
      grant_i_s = !grant_d_s && bus.i_read;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_n_s = SERVE_D;
        end else if (grant_i_s) begin
          state_n_s = SERVE_I;
        end else begin
          state_n_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.m_resp) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = state_r;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Latch the winner's request fields at grant. A simultaneous read and
  // write from D is a protocol error, and it is treated as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= OP_NONE;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {LINE_W{1'b0}};
    end else if (grant_d_s) begin
      op_r    <= bus.d_write ? OP_WRITE : OP_READ;
      addr_r  <= bus.d_addr;
      wdata_r <= bus.d_wdata;
    end else if (grant_i_s) begin
      op_r    <= OP_READ;
      addr_r  <= bus.i_addr;
    end
  end

  // Anti-starvation counter: counts D grants issued while I is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_i_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_d_s && bus.i_read) begin
      if (starve_cnt_r < STARVE_MAX_C) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end
    end else if ((state_r == IDLE) && !bus.i_read) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Memory requests come from state and latched fields only. They stay high
  // through the m_resp cycle and drop when the FSM reaches IDLE.
  assign bus.m_addr  = addr_r;
  assign bus.m_wdata = wdata_r;
  assign bus.m_read  = (state_r != IDLE) && (op_r == OP_READ);
  assign bus.m_write = (state_r != IDLE) && (op_r == OP_WRITE);
  assign bus.busy    = (state_r != IDLE);

  // Responses pass m_resp straight through to the current winner. A stray
  // m_resp in IDLE therefore reaches nobody.
  assign bus.i_resp  = (state_r == SERVE_I) && bus.m_resp;
  assign bus.d_resp  = (state_r == SERVE_D) && bus.m_resp;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven checks of mem_arbiter, plus
// hand-written sequences for starvation and mid-transaction reset.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic              i_read;
    logic [31:0]       i_addr;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              m_resp;
    logic [LINE_W-1:0] m_rdata;
    logic              e_m_read;
    logic              e_m_write;
    logic              e_busy;
    logic              e_i_resp;
    logic              e_d_resp;
    logic              chk_addr;
    logic [31:0]       e_m_addr;
    logic [LINE_W-1:0] e_m_wdata;
  } vec_t;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0b expected=%0b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  vec_t              vecs [18];
  logic [LINE_W-1:0] a_line;
  logic [LINE_W-1:0] f_line;
  logic [LINE_W-1:0] z_line;
  logic [LINE_W-1:0] c_line;
  logic [LINE_W-1:0] r_line;
  logic              exp_i [6];
  logic [2:0]        exp_cnt [6];

  initial begin
    checks = 0;
    errors = 0;
    a_line = {8{32'hAAAA_AAAA}};
    f_line = {8{32'h5555_5555}};
    z_line = {LINE_W{1'b0}};
    c_line = {8{32'h1234_5678}};
    r_line = {8{32'h5A5A_5A5A}};

    //          ir    iaddr      dr    dw    daddr      wdata   mr    rdata   erd   ewr   busy  iresp dresp chk   eaddr      ewdata
    // Single I read at 0x60, memory responds on cycle 4
    vecs[0]  = '{1'b1, 32'h060, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000, z_line};
    vecs[1]  = '{1'b1, 32'h060, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h060, z_line};
    vecs[2]  = '{1'b1, 32'h060, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h060, z_line};
    vecs[3]  = '{1'b1, 32'h060, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h060, z_line};
    vecs[4]  = '{1'b1, 32'h060, 1'b0, 1'b0, 32'h000, z_line, 1'b1, a_line, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h060, z_line};
    vecs[5]  = '{1'b0, 32'h060, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};
    // Simultaneous I read 0x100 and D write 0x200: D first, then I
    vecs[6]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h200, f_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};
    vecs[7]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h200, f_line, 1'b0, z_line, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, f_line};
    vecs[8]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h200, f_line, 1'b1, c_line, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, f_line};
    vecs[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};
    vecs[10] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, z_line};
    vecs[11] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h000, z_line, 1'b1, a_line, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, z_line};
    vecs[12] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};
    // Stray m_resp in IDLE
    vecs[13] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h000, z_line, 1'b1, a_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};
    // D read 0x300, then request dropped and addr changed mid-transaction
    vecs[14] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h300, z_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};
    vecs[15] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h400, z_line, 1'b0, z_line, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, z_line};
    vecs[16] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h400, z_line, 1'b1, r_line, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, z_line};
    vecs[17] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h000, z_line, 1'b0, z_line, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000, z_line};

    // Starvation: grant order D,D,D,D,I,D with starve_cnt seen in IDLE
    exp_i[0] = 1'b0; exp_i[1] = 1'b0; exp_i[2] = 1'b0;
    exp_i[3] = 1'b0; exp_i[4] = 1'b1; exp_i[5] = 1'b0;
    exp_cnt[0] = 3'd0; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
    exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4; exp_cnt[5] = 3'd0;

    // Reset with idle inputs and check the reset values
    rst         = 1'b1;
    bus.i_addr  = 32'h0;
    bus.i_read  = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_wdata = z_line;
    bus.m_rdata = z_line;
    bus.m_resp  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_m_read", bus.m_read, 1'b0);
    chk1("rst_m_write", bus.m_write, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_i_resp", bus.i_resp, 1'b0);
    chk1("rst_d_resp", bus.d_resp, 1'b0);
    chkw("rst_m_addr", 256'(bus.m_addr), z_line);
    chkw("rst_m_wdata", bus.m_wdata, z_line);
    chkw("rst_starve_cnt", 256'(dut.starve_cnt_r), z_line);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven cycles: drive just after negedge, sample 1 time unit later
    for (int k = 0; k < 18; k++) begin
      bus.i_read  = vecs[k].i_read;
      bus.i_addr  = vecs[k].i_addr;
      bus.d_read  = vecs[k].d_read;
      bus.d_write = vecs[k].d_write;
      bus.d_addr  = vecs[k].d_addr;
      bus.d_wdata = vecs[k].d_wdata;
      bus.m_resp  = vecs[k].m_resp;
      bus.m_rdata = vecs[k].m_rdata;
      #1;
      chk1($sformatf("v%0d_m_read", k), bus.m_read, vecs[k].e_m_read);
      chk1($sformatf("v%0d_m_write", k), bus.m_write, vecs[k].e_m_write);
      chk1($sformatf("v%0d_busy", k), bus.busy, vecs[k].e_busy);
      chk1($sformatf("v%0d_i_resp", k), bus.i_resp, vecs[k].e_i_resp);
      chk1($sformatf("v%0d_d_resp", k), bus.d_resp, vecs[k].e_d_resp);
      chkw($sformatf("v%0d_i_rdata", k), bus.i_rdata, vecs[k].m_rdata);
      chkw($sformatf("v%0d_d_rdata", k), bus.d_rdata, vecs[k].m_rdata);
      if (vecs[k].chk_addr) begin
        chkw($sformatf("v%0d_m_addr", k), 256'(bus.m_addr), 256'(vecs[k].e_m_addr));
      end
      if (vecs[k].e_m_write) begin
        chkw($sformatf("v%0d_m_wdata", k), bus.m_wdata, vecs[k].e_m_wdata);
      end
      @(negedge clk);
    end

    // Starvation sequence: I held high, D re-requests after every response
    bus.i_read = 1'b1;
    bus.i_addr = 32'h700;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h800;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1($sformatf("st%0d_idle_busy", k), bus.busy, 1'b0);
      chkw($sformatf("st%0d_cnt_idle", k), 256'(dut.starve_cnt_r), 256'(exp_cnt[k]));
      @(negedge clk);
      #1;
      chk1($sformatf("st%0d_busy", k), bus.busy, 1'b1);
      chk1($sformatf("st%0d_grant_is_i", k), (bus.m_addr == 32'h700), exp_i[k]);
      if (exp_i[k]) begin
        chkw($sformatf("st%0d_cnt_after_i", k), 256'(dut.starve_cnt_r), z_line);
      end
      bus.m_resp = 1'b1;
      #1;
      chk1($sformatf("st%0d_i_resp", k), bus.i_resp, exp_i[k]);
      chk1($sformatf("st%0d_d_resp", k), bus.d_resp, !exp_i[k]);
      @(negedge clk);
      bus.m_resp = 1'b0;
      if (!exp_i[k]) begin
        bus.d_addr = bus.d_addr + 32'h40;
      end
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    @(negedge clk);

    // Reset in the middle of a D write; a late m_resp must be ignored
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h900;
    bus.d_wdata = f_line;
    @(negedge clk);
    #1;
    chk1("rs_m_write_before", bus.m_write, 1'b1);
    chk1("rs_busy_before", bus.busy, 1'b1);
    rst         = 1'b1;
    bus.d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rs_m_write_after", bus.m_write, 1'b0);
    chk1("rs_busy_after", bus.busy, 1'b0);
    chkw("rs_m_addr_after", 256'(bus.m_addr), z_line);
    chkw("rs_state_after", 256'(dut.state_r), z_line);
    bus.m_resp = 1'b1;
    #1;
    chk1("rs_late_d_resp", bus.d_resp, 1'b0);
    chk1("rs_late_i_resp", bus.i_resp, 1'b0);
    @(negedge clk);
    bus.m_resp = 1'b0;
    #1;
    chkw("rs_state_late", 256'(dut.state_r), z_line);
    chk1("rs_busy_late", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single cacheline-wide memory port between the instruction-fetch requester (I side) and the data requester (D side).
- Sits between the two caches and the memory model / burst adapter.
- D side has fixed priority over I side, bounded by an anti-starvation counter.
- One transaction is outstanding at a time; request fields are latched at grant.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, line data width.
- STARVE_MAX, 4, maximum consecutive D grants issued while I is waiting; the next grant is forced to I. Must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_addr  in  ADDR_W  I line address
- i_read  in  1  I read request (level)
- i_rdata  out  LINE_W  I read data
- i_resp  out  1  I completion pulse
- d_addr  in  ADDR_W  D line address
- d_read  in  1  D read request (level)
- d_write  in  1  D write request (level)
- d_wdata  in  LINE_W  D write data
- d_rdata  out  LINE_W  D read data
- d_resp  out  1  D completion pulse
- m_addr  out  ADDR_W  memory address
- m_read  out  1  memory read request
- m_write  out  1  memory write request
- m_wdata  out  LINE_W  memory write data
- m_rdata  in  LINE_W  memory read data
- m_resp  in  1  memory completion pulse (1 cycle)
- busy  out  1  transaction outstanding

Behaviour:

States: IDLE, SERVE_I, SERVE_D. Reset puts the FSM in IDLE.
- Reset values: state IDLE, starve_cnt 0.
- Latched addr and wdata registers reset to 0; latched op resets to none.
- Outputs during and after reset: m_read=m_write=0, m_addr=0, m_wdata=0, i_resp=d_resp=0, busy=0.

IDLE:
- If d_req (d_read|d_write) and either !i_read or starve_cnt<STARVE_MAX: latch d_addr, d_wdata and op, then go to SERVE_D.
- Else if i_read: latch i_addr with op=read, then go to SERVE_I.
- Else stay in IDLE.
- d_read and d_write both high is a protocol error; it is treated as a write.

SERVE_x:
- m_addr, m_wdata, m_read and m_write are driven only from the latched registers, never combinationally from requester inputs.
- busy=1.
- Hold until m_resp=1.

m_resp cycle:
- The winner's resp is driven combinationally the same cycle (x_resp=m_resp).
- Next state is IDLE.
- m_read/m_write remain high through the resp cycle and drop the following cycle.

Data paths:
- i_rdata = m_rdata and d_rdata = m_rdata at all times.
- Validity is qualified only by the matching resp.
- The non-winner's resp is 0.

Latency:
- Request seen in IDLE at cycle 0 -> m_* asserted at cycle 1 -> requester resp in the same cycle as m_resp.
- Minimum 2 cycles request-to-resp.
- One IDLE cycle separates back-to-back transactions.

starve_cnt, updated on each grant:
- D grant while i_read=1: increment, saturating at STARVE_MAX.
- I grant: clear.
- In IDLE with i_read=0: clear.

Requester contract:
- addr, wdata and op are held until resp.
- The request drops or changes in the cycle after resp; a request present in that cycle is a new request.

Boundary cases:
- Requester drops its request mid-transaction: ignored. The transaction completes and resp still pulses.
- Requester changes addr mid-transaction: ignored, because fields were latched at grant.
- m_resp while in IDLE: ignored, no resp generated.
- rst mid-transaction: FSM returns to IDLE and all outputs read 0 from the next cycle. A late m_resp arriving afterwards is ignored.
- Simultaneous I and D with starve_cnt==STARVE_MAX: I wins, and starve_cnt is cleared.

Test Plan:
1. Single I read: i_read=1, i_addr=0x60 in IDLE at cycle 0 -> cycle 1 m_read=1, m_addr=0x60. Memory pulses m_resp at cycle 4 with m_rdata=0xAAAA..A -> i_resp=1 and i_rdata=0xAAAA..A at cycle 4. m_read=0 at cycle 5.
2. Simultaneous I read 0x100 and D write 0x200 with wdata=0x55..5 -> D is served first (m_write=1, m_addr=0x200, m_wdata=0x55..5) -> after d_resp, one IDLE cycle, then m_read with m_addr=0x100.
3. Starvation, STARVE_MAX=4: i_read held high while D issues back-to-back requests -> grant order D,D,D,D,I,D. starve_cnt reads 4 before the I grant and 0 after it.
4. Mid-transaction drop: D read to 0x300 granted, then d_read dropped and d_addr changed to 0x400 -> m_addr stays 0x300 and d_resp pulses on m_resp.
5. Reset mid-SERVE_D: rst=1 one cycle while m_write=1 -> next cycle m_write=0, busy=0, state IDLE. A later m_resp produces no d_resp.
6. Stray m_resp in IDLE with no requests -> i_resp=d_resp=0 and state stays IDLE.
